gen_scheduler: RTL

// - Shares one generator core (even_fib-style __start/__ready/__valid/__done/__output_0 contract) among NUM_REQ requesters.
// - Each job is one requester's argument n:
//   - accepted round-robin, started on the core;
//   - output stream routed back to that requester only;
//   - completed on the core's done pulse.
// - Sits between requester logic and one core instance; also owns the core's reset and a hang watchdog.

---
 rtl/gen_sched_pkg.sv | 10 +
 rtl/rr_pick.sv | 30 +++
 rtl/gen_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/gen_sched_pkg.sv
// gen_sched_pkg: shared state encoding and index-width helper for the generator scheduler.
package gen_sched_pkg;

    typedef enum logic [1:0] {IDLE, START, RUN, ABORT} state_t;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr (cyclic).
module rr_pick
    import gen_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                grant = '0;
                grant[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/gen_scheduler.sv
// gen_scheduler: shares one generator core among NUM_REQ requesters, round-robin,
// routing each job's output stream back to its owner and aborting hung jobs.
module gen_scheduler
    import gen_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                      __clock,
    input  logic                      __reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_n,
    output logic [NUM_REQ-1:0]        req_grant,
    output logic [NUM_REQ-1:0]        out_valid,
    input  logic [NUM_REQ-1:0]        out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [NUM_REQ-1:0]        out_done,
    output logic [NUM_REQ-1:0]        out_err,
    output logic                      gen_reset,
    output logic                      gen_start,
    output logic [DATA_W-1:0]         gen_n,
    output logic                      gen_ready,
    input  logic                      gen_valid,
    input  logic                      gen_done,
    input  logic [DATA_W-1:0]         gen_data
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int TW = idx_w(TIMEOUT + 1);

    state_t               state, state_d;
    logic [IW-1:0]        rr_ptr, owner, pick_idx;
    logic [NUM_REQ-1:0]   pick_oh, grant_q;
    logic                 pick_any, gen_rst_q, beat, stall, wd_fire;
    logic [TW-1:0]        timer;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        state_d   = state;
        out_valid = '0;
        out_done  = '0;
        out_err   = '0;
        out_data  = '0;
        gen_ready = 1'b0;
        beat      = 1'b0;
        stall     = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            IDLE:  state_d = (!gen_rst_q && pick_any) ? START : IDLE;
            START: state_d = RUN;
            RUN: begin
                out_valid[owner] = gen_valid;
                out_data         = gen_data;
                gen_ready        = out_ready[owner];
                beat             = gen_valid & out_ready[owner];
                // A stalled beat is the requester's doing, not a core hang.
                stall            = gen_valid & ~out_ready[owner];
                wd_fire          = (TIMEOUT != 0) && !gen_done && !beat && !stall
                                   && (timer == TW'(TIMEOUT - 1));
                out_done[owner]  = gen_done;
                state_d          = gen_done ? IDLE : (wd_fire ? ABORT : RUN);
            end
            default: begin
                out_err[owner]  = 1'b1;
                out_done[owner] = 1'b1;
                state_d         = IDLE;
            end
        endcase
    end

    assign gen_start = (state == START);
    assign gen_reset = gen_rst_q | (state == ABORT);
    assign req_grant = grant_q;

    always_ff @(posedge __clock or negedge __reset_n) begin
        if (!__reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            gen_n     <= '0;
            grant_q   <= '0;
            timer     <= '0;
            gen_rst_q <= 1'b1;
        end else begin
            state     <= state_d;
            gen_rst_q <= 1'b0;
            grant_q   <= '0;
            if (state == IDLE && state_d == START) begin
                grant_q <= pick_oh;
                owner   <= pick_idx;
                gen_n   <= req_n[pick_idx * DATA_W +: DATA_W];
                rr_ptr  <= IW'((int'(pick_idx) + 1) % NUM_REQ);
            end
            if (state != RUN || gen_done || beat)
                timer <= '0;
            else if (!stall && timer != '1)
                timer <= timer + 1'b1;
        end
    end

endmodule
